// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake and payload bundle between the ID-stage immediate generator and its neighbours
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      fmt_o;
  logic            illegal_o;
  modport slave (
    input  in_valid_i, instr_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o
  );
  modport master (
    output in_valid_i, instr_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder feeding a 2-entry skid buffer with valid/ready and flush
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter bit SHIFT_BJ   = 1'b0,
  parameter bit ZERO_SHAMT = 1'b1
) (
  input logic          clk_i,
  input logic          rst_i,
  imm_gen_pipe_if.slave bus
);
  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_I     = 3'd1;
  localparam logic [2:0] F_S     = 3'd2;
  localparam logic [2:0] F_B     = 3'd3;
  localparam logic [2:0] F_U     = 3'd4;
  localparam logic [2:0] F_J     = 3'd5;
  localparam logic [2:0] F_SHAMT = 3'd6;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state_q, state_d;
  entry_t m_q, m_d, k_q, k_d, dec;
  logic [31:0] ins;
  logic [2:0]  f3;
  logic [11:0] b_raw;
  logic [19:0] j_raw;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic accept, pop;
  assign ins   = bus.instr_i;
  assign f3    = ins[14:12];
  assign b_raw = {ins[31], ins[7], ins[30:25], ins[11:8]};
  assign j_raw = {ins[31], ins[19:12], ins[20], ins[30:21]};
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = SHIFT_BJ ? XLEN'($signed({b_raw, 1'b0})) : XLEN'($signed(b_raw));
  assign imm_j = SHIFT_BJ ? XLEN'($signed({j_raw, 1'b0})) : XLEN'($signed(j_raw));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  // RV64 shifts carry a 6-bit shamt; bit 25 is part of funct7 on RV32
  assign imm_sh = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
  always_comb begin
    dec = '0;
    case (ins[6:0])
      7'b0000011, 7'b1100111: dec = '{imm: imm_i, fmt: F_I, ill: 1'b0};
      7'b0010011: dec = (ZERO_SHAMT && (f3 == 3'b001 || f3 == 3'b101))
                        ? '{imm: imm_sh, fmt: F_SHAMT, ill: 1'b0}
                        : '{imm: imm_i, fmt: F_I, ill: 1'b0};
      7'b0100011: dec = '{imm: imm_s, fmt: F_S, ill: 1'b0};
      7'b1100011: dec = '{imm: imm_b, fmt: F_B, ill: 1'b0};
      7'b1101111: dec = '{imm: imm_j, fmt: F_J, ill: 1'b0};
      7'b0110111, 7'b0010111: dec = '{imm: imm_u, fmt: F_U, ill: 1'b0};
      7'b0110011, 7'b0001111, 7'b1110011: dec = '{imm: '0, fmt: F_NONE, ill: 1'b0};
      default: dec = '{imm: '0, fmt: F_NONE, ill: 1'b1};
    endcase
  end
  assign bus.in_ready_o  = state_q != FULL;
  assign bus.out_valid_o = state_q != EMPTY;
  assign bus.imm_o       = m_q.imm;
  assign bus.fmt_o       = m_q.fmt;
  assign bus.illegal_o   = m_q.ill;
  assign accept = bus.in_valid_i & bus.in_ready_o;
  assign pop    = bus.out_valid_o & bus.out_ready_i;
  // Flush only invalidates; payload registers keep their stale contents
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          m_d     = accept ? dec : m_q;
          state_d = accept ? ONE : EMPTY;
        end
        ONE: begin
          m_d     = (accept && pop) ? dec : m_q;
          k_d     = (accept && !pop) ? dec : k_q;
          state_d = (accept && !pop) ? FULL : (!accept && pop) ? EMPTY : ONE;
        end
        FULL: begin
          m_d     = pop ? k_q : m_q;
          state_d = pop ? ONE : FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: two parameterisations driven in lockstep, checked against a queue-based decode model
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;
  logic clk, rst, in_valid, flush, out_ready;
  logic [31:0] instr;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  imm_gen_pipe_if #(.XLEN(32)) if0 ();
  imm_gen_pipe_if #(.XLEN(64)) if1 ();
  assign if0.in_valid_i  = in_valid;
  assign if0.instr_i     = instr;
  assign if0.flush_i     = flush;
  assign if0.out_ready_i = out_ready;
  assign if1.in_valid_i  = in_valid;
  assign if1.instr_i     = instr;
  assign if1.flush_i     = flush;
  assign if1.out_ready_i = out_ready;
  imm_gen_pipe #(.XLEN(32), .SHIFT_BJ(1'b0), .ZERO_SHAMT(1'b1)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  imm_gen_pipe #(.XLEN(64), .SHIFT_BJ(1'b1), .ZERO_SHAMT(1'b0)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic longint sx(input logic [31:0] raw, input int n);
    return raw[n-1] ? longint'(raw) - (longint'(1) << n) : longint'(raw);
  endfunction
  function automatic exp_t ref_dec(input logic [31:0] ins, input int xlen, input bit sbj, input bit zs);
    exp_t e;
    longint v = 0;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (op)
      7'h03, 7'h67: begin v = sx(32'(ins[31:20]), 12); e.fmt = 3'd1; end
      7'h13:
        if (zs && (f3 == 3'd1 || f3 == 3'd5)) begin
          v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
          e.fmt = 3'd6;
        end else begin
          v = sx(32'(ins[31:20]), 12);
          e.fmt = 3'd1;
        end
      7'h23: begin v = sx(32'({ins[31:25], ins[11:7]}), 12); e.fmt = 3'd2; end
      7'h63: begin
        v = sx(32'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * (sbj ? 2 : 1);
        e.fmt = 3'd3;
      end
      7'h6F: begin
        v = sx(32'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * (sbj ? 2 : 1);
        e.fmt = 3'd5;
      end
      7'h37, 7'h17: begin v = sx(32'(ins[31:12]), 20) * 4096; e.fmt = 3'd4; end
      7'h33, 7'h0F, 7'h73: v = 0;
      default: e.ill = 1'b1;
    endcase
    e.imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
    return e;
  endfunction
  task automatic check_outputs();
    check("valid0", 64'(if0.out_valid_o), 64'(q0.size() > 0));
    check("ready0", 64'(if0.in_ready_o), 64'(q0.size() < 2));
    check("valid1", 64'(if1.out_valid_o), 64'(q1.size() > 0));
    check("ready1", 64'(if1.in_ready_o), 64'(q1.size() < 2));
    if (q0.size() > 0) begin
      check("imm0", 64'(if0.imm_o), q0[0].imm);
      check("fmt0", 64'(if0.fmt_o), 64'(q0[0].fmt));
      check("ill0", 64'(if0.illegal_o), 64'(q0[0].ill));
    end
    if (q1.size() > 0) begin
      check("imm1", if1.imm_o, q1[0].imm);
      check("fmt1", 64'(if1.fmt_o), 64'(q1[0].fmt));
      check("ill1", 64'(if1.illegal_o), 64'(q1[0].ill));
    end
  endtask
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    bit acc, pp;
    in_valid = v;
    instr = ins;
    out_ready = rdy;
    flush = fl;
    @(posedge clk);
    acc = v && q0.size() < 2 && !fl;
    pp  = q0.size() > 0 && rdy && !fl;
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pp) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (acc) begin
        q0.push_back(ref_dec(ins, 32, 1'b0, 1'b1));
        q1.push_back(ref_dec(ins, 64, 1'b1, 1'b0));
      end
    end
    #1 check_outputs();
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_v0"}, 64'(if0.out_valid_o), 64'd0);
    check({tag, "_r0"}, 64'(if0.in_ready_o), 64'd1);
    check({tag, "_imm0"}, 64'(if0.imm_o), 64'd0);
    check({tag, "_fmt0"}, 64'(if0.fmt_o), 64'd0);
    check({tag, "_ill0"}, 64'(if0.illegal_o), 64'd0);
    check({tag, "_v1"}, 64'(if1.out_valid_o), 64'd0);
    check({tag, "_imm1"}, if1.imm_o, 64'd0);
  endtask
  initial begin
    logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F, 7'h73};
    logic [31:0] r;
    logic [6:0] op;
    rst = 1'b0;
    in_valid = 1'b0;
    instr = 32'h0;
    flush = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    #4 rst = 1'b0;
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    check("tp1_imm0", 64'(if0.imm_o), 64'hFFFF_FFFF);
    check("tp1_fmt0", 64'(if0.fmt_o), 64'd1);
    check("tp1_imm1", if1.imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    check("tp2_imm0", 64'(if0.imm_o), 64'hFFFF_FFFE);
    check("tp2_fmt0", 64'(if0.fmt_o), 64'd3);
    check("tp2_imm1", if1.imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'h123452B7, 1'b1, 1'b0);
    check("tp3_imm0", 64'(if0.imm_o), 64'h1234_5000);
    check("tp3_imm1", if1.imm_o, 64'h0000_0000_1234_5000);
    check("tp3_fmt1", 64'(if1.fmt_o), 64'd4);
    step(1'b1, 32'h4030D093, 1'b1, 1'b0);
    check("tp4_imm0", 64'(if0.imm_o), 64'd3);
    check("tp4_fmt0", 64'(if0.fmt_o), 64'd6);
    check("tp4_imm1", if1.imm_o, 64'h403);
    check("tp4_fmt1", 64'(if1.fmt_o), 64'd1);
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    check("tp4_ill_imm", 64'(if0.imm_o), 64'd0);
    check("tp4_ill", 64'(if0.illegal_o), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00500113, 1'b0, 1'b0);
    step(1'b1, 32'h00A00193, 1'b0, 1'b0);
    check("tp5_full", 64'(if0.in_ready_o), 64'd0);
    step(1'b1, 32'hFFF00213, 1'b0, 1'b0);
    step(1'b1, 32'hFFF00213, 1'b0, 1'b0);
    check("tp5_stable", 64'(if0.imm_o), 64'd5);
    step(1'b1, 32'hFFF00213, 1'b1, 1'b0);
    step(1'b1, 32'hFFF00213, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("tp5_drained", 64'(if0.out_valid_o), 64'd0);
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 1'b0, 1'b1);
    check("tp6_flush_v", 64'(if0.out_valid_o), 64'd0);
    check("tp6_flush_r", 64'(if0.in_ready_o), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    q0.delete();
    q1.delete();
    #2 rst = 1'b0;
    for (int n = 0; n < 800; n++) begin
      r = $urandom();
      op = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) op = r[6:0];
      step($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom_range(0, 9) < 6,
           $urandom_range(0, 29) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised RISC-V immediate generator for the ID stage of the pipelined core. It decodes all base immediate formats (I, S, B, U, J, shift-amount) into a sign-extended XLEN-bit immediate and a format code. Results pass through a 2-entry skid buffer with a valid/ready handshake, so ID/EX back-pressure never drops an instruction. A synchronous flush input discards in-flight entries on a branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; all immediates sign- or zero-extended to XLEN.
SHIFT_BJ, 0, 0: B/J immediates are the raw offset fields imm[12:1]/imm[20:1] sign-extended, with no trailing 0; 1: full byte offset with LSB = 0.
ZERO_SHAMT, 1, 1: OP-IMM shifts output the zero-extended shamt only; 0: treat them as plain I-type.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
in_valid_i  in  1  instr_i valid
in_ready_o  out  1  block can accept this cycle
instr_i  in  32  instruction word
flush_i  in  1  synchronous flush of all stored entries
out_valid_o  out  1  imm_o/fmt_o/illegal_o valid
out_ready_i  in  1  consumer accepts this cycle
imm_o  out  XLEN  decoded immediate
fmt_o  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
illegal_o  out  1  opcode not recognised

Behaviour:
- Decode (combinational on instr_i, opcode = instr_i[6:0]):
  - 0000011, 0010011, 1100111 -> I: sext(instr[31:20]).
  - 0010011 with funct3 001/101 and ZERO_SHAMT=1 -> SHAMT: zext(instr[24:20]) for XLEN=32, zext(instr[25:20]) for XLEN=64.
  - 0100011 -> S: sext({instr[31:25], instr[11:7]}).
  - 1100011 -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8]}); append 1'b0 if SHIFT_BJ=1.
  - 1101111 -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21]}); append 1'b0 if SHIFT_BJ=1.
  - 0110111, 0010111 -> U: sext({instr[31:12], 12'b0}).
  - 0110011, 0001111, 1110011 -> NONE, imm 0, illegal 0.
  - Any other opcode -> NONE, imm 0, illegal 1.
- Storage: main register M (drives outputs) and skid register K.
  - States: EMPTY (M, K invalid), ONE (M valid), FULL (M and K valid).
  - accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Ready and valid:
  - in_ready_o = !K.valid, driven only from registered state (no combinational path from out_ready_i).
  - out_valid_o = M.valid.
- Transitions:
  - EMPTY: accept -> ONE (decode loads M).
  - ONE: accept & !pop -> FULL (decode loads K); accept & pop -> ONE (decode loads M); pop only -> EMPTY; neither -> hold.
  - FULL: pop -> ONE (K moves to M); otherwise hold. No accept is possible while in_ready_o = 0.
- Latency: 1 cycle from accept to out_valid_o when the buffer is empty. Strict FIFO order is preserved.
- Stability: while out_valid_o & !out_ready_i, imm_o/fmt_o/illegal_o hold constant.
- Flush: flush_i has priority over all other events. Next state is EMPTY, and any input presented in the same cycle is dropped, even if in_valid_i and in_ready_o are both high.
- Reset:
  - Asynchronous on rst_i high; EMPTY immediately.
  - Outputs during and after reset: out_valid_o = 0, imm_o = 0, fmt_o = 0, illegal_o = 0, in_ready_o = 1.
  - Reset mid-transfer discards M and K.
- Payload registers update only on load; invalid entries keep their last value, except that reset clears them.

Test Plan:
1. Idle buffer, 0xFFF00093 (addi x1,x0,-1) presented for one cycle -> next cycle out_valid_o = 1, imm_o = 0xFFFFFFFF, fmt_o = 1, illegal_o = 0.
2. 0xFE000EE3 (beq x0,x0,-4) -> SHIFT_BJ=1: imm_o = 0xFFFFFFFC, fmt_o = 3; SHIFT_BJ=0: imm_o = 0xFFFFFFFE.
3. 0x123452B7 (lui x5,0x12345) -> imm_o = 0x12345000, fmt_o = 4. With XLEN=64: imm_o = 0x0000000012345000.
4. 0x4030D093 (srai x1,x1,3) -> ZERO_SHAMT=1: imm_o = 3, fmt_o = 6; ZERO_SHAMT=0: imm_o = 0x403, fmt_o = 1. Opcode 0x7F -> imm_o = 0, illegal_o = 1.
5. out_ready_i = 0, push A, B, C back-to-back:
   - A and B accepted; in_ready_o falls the cycle after B; C stalls.
   - Raise out_ready_i -> A, B, C emerge in order with no loss or duplication.
   - imm_o stays stable while stalled.
6. Buffer FULL, assert flush_i with in_valid_i = 1 -> next cycle out_valid_o = 0 and in_ready_o = 1; the flushed input never appears. Separately, assert rst_i asynchronously mid-stall -> outputs zero without a clock edge.
